// File: rtl/jtroadf_snd_pkg.sv
// Shared constants and types for the Road Fighter sound-side interface.
package jtroadf_snd_pkg;
  localparam int TIMER_DIV = 1024;
  localparam int TIMER_W   = 4;
  localparam int LATCH_W   = 8;

  typedef logic [LATCH_W-1:0] snd_cmd_t;
endpackage

// File: rtl/jtroadf_snd_timer.sv
// Konami sound timer: prescaler on the Z80 clock enable feeding a small
// free-running counter that the Z80 samples at its timer port.
module jtroadf_snd_timer
  import jtroadf_snd_pkg::*;
#(
  parameter int DIV = TIMER_DIV,
  parameter int W   = TIMER_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cen,
  output logic [W-1:0] timer
);
  localparam int PW = $clog2(DIV);

  logic [PW-1:0] pre_reg;
  logic [W-1:0]  timer_reg;

  // Counter steps on the same edge the prescaler wraps back to zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pre_reg   <= '0;
      timer_reg <= '0;
    end else if (cen) begin
      pre_reg <= pre_reg + 1'b1;
      if (&pre_reg) timer_reg <= timer_reg + 1'b1;
    end
  end

  assign timer = timer_reg;
endmodule

// File: rtl/jtroadf_sndif.sv
// Main-CPU to Z80 sound interface: command latch with full/overrun flags,
// edge-triggered level interrupt with acknowledge, and the sound timer.
module jtroadf_sndif
  import jtroadf_snd_pkg::*;
#(
  parameter int TIMER_DIV = jtroadf_snd_pkg::TIMER_DIV,
  parameter int TIMER_W   = jtroadf_snd_pkg::TIMER_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               main_cen,
  input  logic               main_rnw,
  input  logic [LATCH_W-1:0] main_dout,
  input  logic               snd_data_cs,
  input  logic               snd_irq,
  input  logic               snd_cen,
  input  logic               latch_rd,
  input  logic               int_ack,
  output logic [LATCH_W-1:0] snd_latch,
  output logic               latch_full,
  output logic               overrun,
  output logic               snd_int_n,
  output logic [TIMER_W-1:0] timer
);
  snd_cmd_t latch_reg;
  logic     full_reg, overrun_reg, int_n_reg, irq_l_reg;
  logic     wr, rd, irq_edge, ack;

  assign wr       = main_cen & snd_data_cs & ~main_rnw;
  assign rd       = snd_cen & latch_rd;
  assign irq_edge = main_cen & snd_irq & ~irq_l_reg;
  assign ack      = snd_cen & int_ack;

  // A read landing on the same clock as a write consumes the old byte,
  // so it is not counted as an overrun and the new byte stays pending.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      latch_reg   <= '0;
      full_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (wr) begin
      latch_reg <= main_dout;
      full_reg  <= 1'b1;
      if (full_reg && !rd) overrun_reg <= 1'b1;
    end else if (rd) begin
      full_reg <= 1'b0;
    end
  end

  // Set has priority over acknowledge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_l_reg <= 1'b0;
      int_n_reg <= 1'b1;
    end else begin
      if (main_cen) irq_l_reg <= snd_irq;
      if (irq_edge) int_n_reg <= 1'b0;
      else if (ack) int_n_reg <= 1'b1;
    end
  end

  jtroadf_snd_timer #(
    .DIV (TIMER_DIV),
    .W   (TIMER_W)
  ) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .cen   (snd_cen),
    .timer (timer)
  );

  assign snd_latch  = latch_reg;
  assign latch_full = full_reg;
  assign overrun    = overrun_reg;
  assign snd_int_n  = int_n_reg;
endmodule

// File: tb/tb_jtroadf_sndif.sv
// Self-checking bench for jtroadf_sndif: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_jtroadf_sndif;
  logic       clk = 1'b0;
  logic       rstn, main_cen, main_rnw, snd_data_cs, snd_irq, snd_cen, latch_rd, int_ack;
  logic [7:0] main_dout;
  logic [7:0] snd_latch, snd_latch4;
  logic       latch_full, overrun, snd_int_n, latch_full4, overrun4, snd_int_n4;
  logic [3:0] timer, timer4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jtroadf_sndif dut (
    .clk(clk), .rstn(rstn), .main_cen(main_cen), .main_rnw(main_rnw),
    .main_dout(main_dout), .snd_data_cs(snd_data_cs), .snd_irq(snd_irq),
    .snd_cen(snd_cen), .latch_rd(latch_rd), .int_ack(int_ack),
    .snd_latch(snd_latch), .latch_full(latch_full), .overrun(overrun),
    .snd_int_n(snd_int_n), .timer(timer)
  );

  jtroadf_sndif #(.TIMER_DIV(4)) dut4 (
    .clk(clk), .rstn(rstn), .main_cen(main_cen), .main_rnw(main_rnw),
    .main_dout(main_dout), .snd_data_cs(snd_data_cs), .snd_irq(snd_irq),
    .snd_cen(snd_cen), .latch_rd(latch_rd), .int_ack(int_ack),
    .snd_latch(snd_latch4), .latch_full(latch_full4), .overrun(overrun4),
    .snd_int_n(snd_int_n4), .timer(timer4)
  );

  // Behavioural model: pending command, sticky error, pending interrupt,
  // and a count of snd_cen pulses since reset from which the timer follows.
  logic [7:0] m_data;
  bit         m_full, m_ov, m_pend, m_irq_prev;
  int         m_pulses;

  function automatic logic [3:0] exp_timer(input int div);
    return 4'((m_pulses / div) % 16);
  endfunction

  task automatic model_edge();
    bit wr, rd, rise;
    if (!rstn) begin
      m_data = 8'h00; m_full = 0; m_ov = 0; m_pend = 0; m_irq_prev = 0; m_pulses = 0;
      return;
    end
    wr   = main_cen && snd_data_cs && !main_rnw;
    rd   = snd_cen && latch_rd;
    rise = main_cen && snd_irq && !m_irq_prev;
    if (wr) begin
      if (m_full && !rd) m_ov = 1;
      m_data = main_dout;
      m_full = 1;
    end else if (rd) m_full = 0;
    if (main_cen) m_irq_prev = snd_irq;
    if (rise) m_pend = 1;
    else if (snd_cen && int_ack) m_pend = 0;
    if (snd_cen) m_pulses++;
  endtask

  // One clock: drive inputs, take the edge, compare every output to the model.
  task automatic cycle(input logic r, mc, rnw, input logic [7:0] d,
                       input logic cs, irq, sc, rdx, ack);
    rstn = r; main_cen = mc; main_rnw = rnw; main_dout = d; snd_data_cs = cs;
    snd_irq = irq; snd_cen = sc; latch_rd = rdx; int_ack = ack;
    @(posedge clk);
    model_edge();
    #1;
    n_vec++;
    if (snd_latch !== m_data || latch_full !== m_full || overrun !== m_ov ||
        snd_int_n !== !m_pend || timer !== exp_timer(1024) || timer4 !== exp_timer(4)) begin
      n_bad++;
      $display("FAIL model t=%0t latch=%h/%h full=%b/%b ovr=%b/%b int_n=%b/%b timer=%0d/%0d timer4=%0d/%0d",
               $time, snd_latch, m_data, latch_full, m_full, overrun, m_ov,
               snd_int_n, !m_pend, timer, exp_timer(1024), timer4, exp_timer(4));
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input logic irq);
    cycle(1, 0, 1, 8'h00, 0, irq, 0, 0, 0);
  endtask

  typedef struct {
    logic       r, mc, rnw, cs, irq, sc, rd, ack;
    logic [7:0] d;
    logic [7:0] e_latch;
    logic       e_full, e_ov, e_int_n;
  } vec_t;

  vec_t tbl[15];

  initial begin
    //           r  mc rnw cs irq sc rd ack d       latch full ov int_n
    tbl[0]  = '{0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 1, 0, 0, 0, 0, 8'h5A, 8'h5A, 1, 0, 1};
    tbl[3]  = '{1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h5A, 1, 0, 1};
    tbl[4]  = '{1, 0, 1, 0, 0, 1, 1, 0, 8'h00, 8'h5A, 0, 0, 1};
    tbl[5]  = '{1, 1, 0, 1, 0, 0, 0, 0, 8'h11, 8'h11, 1, 0, 1};
    tbl[6]  = '{1, 1, 0, 1, 0, 0, 0, 0, 8'h22, 8'h22, 1, 1, 1};
    tbl[7]  = '{1, 0, 1, 0, 0, 1, 1, 0, 8'h00, 8'h22, 0, 1, 1};
    tbl[8]  = '{1, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h22, 0, 1, 0};
    tbl[9]  = '{1, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h22, 0, 1, 0};
    tbl[10] = '{1, 0, 1, 0, 1, 1, 0, 1, 8'h00, 8'h22, 0, 1, 1};
    tbl[11] = '{1, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h22, 0, 1, 1};
    tbl[12] = '{1, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h22, 0, 1, 1};
    tbl[13] = '{1, 1, 1, 0, 1, 1, 0, 1, 8'h00, 8'h22, 0, 1, 0};
    tbl[14] = '{1, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h22, 0, 1, 0};

    m_data = 0; m_full = 0; m_ov = 0; m_pend = 0; m_irq_prev = 0; m_pulses = 0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].r, tbl[i].mc, tbl[i].rnw, tbl[i].d, tbl[i].cs,
            tbl[i].irq, tbl[i].sc, tbl[i].rd, tbl[i].ack);
      n_vec++;
      if (snd_latch !== tbl[i].e_latch || latch_full !== tbl[i].e_full ||
          overrun !== tbl[i].e_ov || snd_int_n !== tbl[i].e_int_n) begin
        n_bad++;
        $display("FAIL table[%0d] latch=%h/%h full=%b/%b ovr=%b/%b int_n=%b/%b", i,
                 snd_latch, tbl[i].e_latch, latch_full, tbl[i].e_full,
                 overrun, tbl[i].e_ov, snd_int_n, tbl[i].e_int_n);
      end
    end

    // Write while full with a read on the same clock: no overrun
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 8'hAA, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 8'hBB, 1, 0, 1, 1, 0);
    chk("simul_latch", snd_latch, 8'hBB);
    chk("simul_full", latch_full, 1);
    chk("simul_ovr", overrun, 0);

    // Held IRQ level produces a single request
    cycle(1, 1, 1, 8'h00, 0, 1, 0, 0, 0);
    chk("irq_set", snd_int_n, 0);
    for (int i = 0; i < 100; i++) cycle(1, 1, 1, 8'h00, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 8'h00, 0, 1, 1, 0, 1);
    chk("irq_ack", snd_int_n, 1);
    for (int i = 0; i < 20; i++) cycle(1, 1, 1, 8'h00, 0, 1, 0, 0, 0);
    chk("irq_no_retrigger", snd_int_n, 1);

    // Timer: first step after exactly 1024 pulses, wrap after 16x1024
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16384; i++) begin
      cycle(1, 0, 1, 8'h00, 0, 0, 1, 0, 0);
      if (i == 3)     chk("timer4_before", timer4, 0);
      if (i == 4)     chk("timer4_first", timer4, 1);
      if (i == 1023)  chk("timer_before", timer, 0);
      if (i == 1024)  chk("timer_first", timer, 1);
      if (i == 16383) chk("timer_top", timer, 15);
      if (i == 16384) chk("timer_wrap", timer, 0);
    end

    // Reset mid-operation
    for (int i = 0; i < 7 * 1024; i++) cycle(1, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 8'h77, 1, 1, 0, 0, 0);
    cycle(1, 1, 0, 8'h78, 1, 1, 0, 0, 0);
    chk("pre_rst_full", latch_full, 1);
    chk("pre_rst_int", snd_int_n, 0);
    chk("pre_rst_timer", timer, 7);
    cycle(0, 0, 1, 8'h00, 0, 1, 0, 0, 0);
    chk("rst_latch", snd_latch, 0);
    chk("rst_full", latch_full, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_int", snd_int_n, 1);
    chk("rst_timer", timer, 0);
    idle(0);

    // Randomized traffic against the model
    begin
      logic irq_lvl;
      irq_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) irq_lvl = ~irq_lvl;
        cycle(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 3) == 0), 8'($urandom), logic'($urandom_range(0, 1)),
              irq_lvl, logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0),
              logic'($urandom_range(0, 3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/jtroadf_sndif.md
Name: jtroadf_sndif

Overview:
- Sound-side interface between the Road Fighter / Hyper Sports main 6809 and the Z80 sound CPU.
- Consumes the main CPU's sound-data chip-select, write data and snd_irq latch bit.
- Provides the Z80 with:
  - a command latch and full flag;
  - a level interrupt line with acknowledge handshake;
  - the free-running 4-bit Konami sound timer read at the timer port.
- Sits directly downstream of the main CPU block, upstream of the sound CPU wrapper.

Parameters:
- TIMER_DIV, 1024, snd_cen ticks per timer increment; power of two, minimum 2.
- TIMER_W, 4, timer counter width.

Ports:
- clk  input  1  system clock (24 MHz)
- rstn  input  1  synchronous reset, active low; one clock, reset is synchronous and active-low
- main_cen  input  1  main CPU cycle enable (Q clock)
- main_rnw  input  1  main CPU read/not-write
- main_dout  input  8  main CPU write data
- snd_data_cs  input  1  main CPU sound-latch chip select
- snd_irq  input  1  main CPU sound IRQ latch bit (level)
- snd_cen  input  1  Z80 clock enable (~3.58 MHz)
- latch_rd  input  1  Z80 read strobe of latch port, valid on snd_cen
- int_ack  input  1  Z80 interrupt acknowledge (IORQ & M1), valid on snd_cen
- snd_latch  output  8  latched command byte
- latch_full  output  1  unread command present
- overrun  output  1  sticky: write while full
- snd_int_n  output  1  Z80 INT, active low
- timer  output  TIMER_W  timer value for the Z80 timer port

Behaviour:
- Reset (rstn=0 at a clk edge):
  - snd_latch=0, latch_full=0, overrun=0, snd_int_n=1, timer=0;
  - prescaler=0, irq edge register=0.
  - Reset mid-operation discards the pending command and interrupt immediately.
- All state updates on clk posedge. Main-side events qualify with main_cen; Z80-side events qualify with snd_cen.

Latch write:
- main_cen & snd_data_cs & !main_rnw → snd_latch<=main_dout, latch_full<=1.
- Visible on snd_latch one clk after the qualifying edge.
- If latch_full already 1 at the write → overrun<=1 (sticky until reset) and data is overwritten.

Latch read:
- snd_cen & latch_rd → latch_full<=0.
- snd_latch keeps its value; reads are non-destructive.

Simultaneous write and read in the same clk:
- Data updates, latch_full stays 1, overrun not set.

IRQ:
- snd_irq_l <= snd_irq on main_cen.
- Rising edge (snd_irq & !snd_irq_l at main_cen) → snd_int_n<=0 on the next clk.
- Held level-low until snd_cen & int_ack → snd_int_n<=1.
- Set and ack in the same clk: set wins (snd_int_n=0).
- A high level on snd_irq does not retrigger; only 0→1 transitions trigger.
- An edge while already pending is absorbed (no count).

Timer:
- Prescaler of log2(TIMER_DIV) bits increments on snd_cen.
- On wrap (all ones → 0), timer <= timer+1 modulo 2^TIMER_W.
- Free-running, unaffected by reads.
- timer changes exactly every TIMER_DIV snd_cen pulses; the first increment comes TIMER_DIV pulses after reset.

Other rules:
- main_cen and snd_cen may coincide; the paths are independent except for the simultaneous cases listed above.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package jtroadf_snd_pkg:
  - TIMER_DIV default 1024;
  - TIMER_W default 4;
  - LATCH_W 8.
- One natural sub-module: jtroadf_snd_timer (prescaler + TIMER_W counter, ports clk, rstn, cen, timer).
- Latch, flags and IRQ logic stay in jtroadf_sndif.

Test Plan:
1. Reset then write: rstn low 2 clks; main write 0x5A with snd_data_cs → snd_latch=0x5A one clk later, latch_full=1, overrun=0.
2. Read and overrun:
   - Z80 latch_rd at snd_cen → latch_full=0.
   - Then two writes 0x11, 0x22 without read → snd_latch=0x22, overrun=1, stays 1 after a later read.
3. IRQ edge/ack:
   - snd_irq 0→1 at main_cen → snd_int_n=0 next clk; holding snd_irq=1 for 100 main_cen keeps one request.
   - int_ack at snd_cen → snd_int_n=1, not reasserted until snd_irq 1→0→1.
4. Simultaneous set/ack: new snd_irq rising edge and int_ack in the same clk → snd_int_n=0 afterwards.
5. Timer:
   - After reset, 1023 snd_cen pulses → timer=0; 1024th → timer=1.
   - After 16×1024 pulses → timer wraps to 0.
   - TIMER_DIV=4 variant increments every 4 pulses.
6. Reset mid-operation: latch_full=1, snd_int_n=0, timer=7, then rstn low one clk → all outputs return to reset values on the next edge.
